// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data_ram arbiter: FSM state encodings,
// priority-mode selectors and the common RAM control constants.
package data_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbBusy = 2'd1,
        ArbResp = 2'd2
    } arb_state_t;

    localparam logic PrioRoundRobin = 1'b0;
    localparam logic PrioFixed      = 1'b1;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        ChipEnable   = 1'b1;
    localparam logic        ChipDisable  = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

endpackage

// File: rtl/data_ram_arbiter_arb_rr2.sv
// Combinational two-way grant picker: a lone requester always wins; on a tie
// the port that did not win last time wins, unless fixed priority favours port 0.
module arb_rr2
    import data_ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       prio_mode,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (req == 2'b10) begin
            grant_id = 1'b1;
        end else if (req == 2'b11) begin
            grant_id = (prio_mode == PrioFixed) ? 1'b0 : ~last_grant;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data_ram between the CPU MEM stage (port 0) and the
// loader/debug port (port 1): grant, one RAM cycle, one ack cycle.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_sel,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_sel,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_ack,
    output logic              stall_req,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_i
);

    localparam logic PrioSel = (PRIO_MODE == 0) ? PrioRoundRobin : PrioFixed;

    arb_state_t        state;
    logic              last_grant;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        lat_sel;
    logic [31:0]       lat_wdata;
    logic              grant_id;
    logic              grant_valid;

    arb_rr2 u_pick (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant),
        .prio_mode   (PrioSel),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // last_grant resets to port 1 so that port 0 wins the very first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ArbIdle;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_sel    <= 4'h0;
            lat_wdata  <= ZeroWord;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= ZeroWord;
            m1_rdata   <= ZeroWord;
        end else begin
            unique case (state)
                ArbIdle: begin
                    if (grant_valid) begin
                        lat_id     <= grant_id;
                        last_grant <= grant_id;
                        lat_we     <= grant_id ? m1_we    : m0_we;
                        lat_addr   <= grant_id ? m1_addr  : m0_addr;
                        lat_sel    <= grant_id ? m1_sel   : m0_sel;
                        lat_wdata  <= grant_id ? m1_wdata : m0_wdata;
                        state      <= ArbBusy;
                    end
                end
                ArbBusy: begin
                    if (!lat_we) begin
                        if (lat_id) begin
                            m1_rdata <= ram_data_i;
                        end else begin
                            m0_rdata <= ram_data_i;
                        end
                    end
                    m0_ack <= ~lat_id;
                    m1_ack <= lat_id;
                    state  <= ArbResp;
                end
                ArbResp: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    state  <= ArbIdle;
                end
                default: state <= ArbIdle;
            endcase
        end
    end

    // RAM sees the latched command only during the single BUSY cycle.
    always_comb begin
        ram_ce     = ChipDisable;
        ram_we     = WriteDisable;
        ram_addr   = '0;
        ram_sel    = 4'h0;
        ram_data_o = ZeroWord;
        if (state == ArbBusy) begin
            ram_ce     = ChipEnable;
            ram_we     = lat_we ? WriteEnable : WriteDisable;
            ram_addr   = lat_addr;
            ram_sel    = lat_sel;
            ram_data_o = lat_wdata;
        end
    end

    assign stall_req = m0_req & ~m0_ack;

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port data_ram between two requesters: port 0 is the CPU MEM stage and port 1 is the program-loader/debug port.
- Arbitrates requests, registers the winning command, and drives the RAM's ce/we/addr/sel/data_i for exactly one cycle.
- Captures the RAM's read data and returns a one-cycle ack to the winner.
- Also raises stall_req toward the pipeline controller while the CPU access is pending.

Parameters:
- ADDR_W, 32, width of requester and RAM address buses.
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  port 0 request; held high until m0_ack.
- m0_we  in  1  port 0 write enable (1 = store).
- m0_addr  in  ADDR_W  port 0 byte address.
- m0_sel  in  4  port 0 byte lanes.
- m0_wdata  in  32  port 0 store data.
- m0_rdata  out  32  port 0 load data, valid only while m0_ack = 1.
- m0_ack  out  1  port 0 completion pulse.
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_rdata, m1_ack: same as port 0, for port 1.
- stall_req  out  1  = m0_req & ~m0_ack (combinational), to the pipeline controller.
- ram_ce  out  1  data_ram chip enable.
- ram_we  out  1  data_ram write enable.
- ram_addr  out  ADDR_W  data_ram address.
- ram_sel  out  4  data_ram byte select.
- ram_data_o  out  32  data to data_ram data_i.
- ram_data_i  in  32  data_ram data_o (combinational read).

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, last_grant = 1, so port 0 wins the first tie.
  - All latched command registers = 0; m0_ack = m1_ack = 0.
  - m0_rdata = m1_rdata = 32'h0; ram_ce = 0.
- States:
  - IDLE: no access.
  - BUSY: RAM access cycle.
  - RESP: ack cycle.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise pick the winner:
    - Only one port requesting: that port wins.
    - Both requesting, PRIO_MODE=0: port ≠ last_grant wins.
    - Both requesting, PRIO_MODE=1: port 0 wins.
  - Latch the winner's we/addr/sel/wdata and winner id; update last_grant; go to BUSY.
- BUSY (exactly 1 cycle):
  - ram_ce = 1; ram_we/addr/sel/data_o come from the latched registers, never directly from requester inputs.
  - The RAM write commits at the closing edge.
  - If latched we = 0, ram_data_i is captured into the winner's rdata register; the other port's rdata is unchanged.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - winner ack = 1, other ack = 0, ram_ce = 0.
  - Requests are not sampled in RESP, so the acked requester drops req here with no re-grant.
  - Go to IDLE.
- Outside BUSY: ram_ce = 0, ram_we = 0, and ram_addr/sel/data_o = 0.
- Latency: req seen in IDLE at cycle T → RAM access at T+1 → ack at T+2. The next grant is possible at T+3.
- Throughput: one access per 3 cycles.
- Write ack: the ack is returned with rdata unchanged.
- sel = 4'b0000 with we = 1: the RAM access is still performed (no bytes written) and ack is still returned.
- A request that drops before ack while still in IDLE is simply not granted. Dropping after the grant does not cancel the access; ack is still issued.
- The losing port's request stays pending and is granted at the next IDLE. With round-robin and both ports continuously requesting, grants alternate 0,1,0,1.
- Reset mid-BUSY: the access is aborted, ram_ce drops immediately, no ack. Partial-cycle write integrity is not guaranteed.
- No ack is ever asserted on both ports in the same cycle.

Decomposition:
- Shared defines file additions:
  - state encodings ArbIdle / ArbBusy / ArbResp (2 bits).
  - PrioRoundRobin / PrioFixed constants.
- Existing ZeroWord, ChipEnable/ChipDisable and WriteEnable/WriteDisable are reused.
- One natural sub-module: arb_rr2, a combinational 2-way grant picker (inputs req[1:0], last_grant, prio_mode; output grant id + valid). The FSM and command latch stay in the top.

Test Plan:
- Single read: preload word 5 = 32'hDEADBEEF; m0 read addr 0x14, sel 4'hF at T → ram_ce=1 at T+1; m0_ack=1 and m0_rdata=32'hDEADBEEF at T+2; stall_req high during T..T+1.
- Byte write then read: m1 write addr 0x20, sel 4'b0010, wdata 32'h0000AB00 over word 32'h11223344 → subsequent m1 read returns 32'h1122AB44.
- Simultaneous requests, PRIO_MODE=0, both held for 4 transactions → ack order m0,m1,m0,m1, acks 3 cycles apart, never overlapping.
- Simultaneous requests, PRIO_MODE=1, m0 re-requesting continuously → m1_ack never asserted while m0_req stays high; m1 is granted at the first IDLE with m0_req=0.
- Reset asserted during BUSY of an m0 write → ram_ce=0 and m0_ack=0 immediately; after release the state is IDLE and a fresh m0 read completes in 3 cycles.
- Requester drops req in its ack cycle and re-raises it 1 cycle later → exactly one ack per request, no duplicate grant from the RESP cycle.
